tpu_seq_ctrl: RTL
=================

Name: tpu_seq_ctrl

Overview:
Top-level sequencer for the NaiveTPU matrix path. It latches M/N/K from the PS register file and runs the job in this order: launches the feature and weight reshapers in parallel, waits for both, then runs the systolic array and the result writeback once per K-tile. It raises a sticky done flag for the PS. It sits between the AXI-lite register bank and the FM/W reshape, PE-array and writeback units.

Parameters:
TILE_K, 16, K elements consumed per compute pass (array depth).
TILE_LOG2, 4, log2(TILE_K); the tile count is computed by shifting.
TO_W, 20, watchdog counter width (used only with the optional feature).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle job launch from the register bank
M  in  16  rows of FM; 0 is illegal
N  in  16  cols of FM / rows of W
K  in  16  cols of W; 0 is illegal
busy  out  1  high from latch until done
done  out  1  sticky level; cleared by start
err  out  1  sticky level; bad dimensions or timeout; cleared by start
cfg_M, cfg_N, cfg_K  out  16 each  latched dimensions, stable while busy
reshape_start  out  1  one-cycle pulse to both reshapers
fm_finish  in  1  FM reshaper finish (level, self-clears on its start)
w_finish  in  1  W reshaper finish (same rules)
comp_start  out  1  one-cycle pulse to the PE array
tile_idx  out  16  current K-tile, stable during COMP and WB
comp_finish  in  1  PE array finish (level, self-clears on its start)
wb_start  out  1  one-cycle pulse to writeback
wb_finish  in  1  writeback finish (level, self-clears on its start)

Behaviour:
- Reset values: all outputs 0, state IDLE, tile counters 0.
- States (one-hot): IDLE, LATCH, RSH, RSH_W, COMP, COMP_W, WB, WB_W, NEXT, FIN.
- IDLE: on start, register M/N/K and clear done and err. Next state LATCH.
- LATCH: if M, N or K is 0, set err and go to FIN. Otherwise compute tiles = ((K-1)>>TILE_LOG2)+1, set tile_idx=0 and go to RSH.
- RSH: drive reshape_start=1 for exactly this cycle. Next state RSH_W.
- RSH_W: ignore the finish inputs in the first cycle (guard; the downstream finish clears at the edge after start). From the second cycle, go to COMP once both fm_finish and w_finish are 1. They may rise in different cycles; each is latched into a local "seen" bit.
- COMP: comp_start pulse, then COMP_W. COMP_W has the same guard cycle and waits for comp_finish, then goes to WB.
- WB: wb_start pulse, then WB_W. WB_W has the guard cycle and waits for wb_finish, then goes to NEXT.
- NEXT: if tile_idx == tiles-1, go to FIN. Otherwise tile_idx+1 and go to COMP. Reshape is not repeated per tile.
- FIN: done=1, busy=0 at the following edge, then IDLE.
- busy=1 in every state except IDLE. It is a registered output and reflects the state one edge after the transition.
- All start pulses are registered, exactly one cycle, and mutually exclusive.
- start while busy: ignored. Registers and state are unchanged.
- start in the same cycle as the FIN→IDLE transition: ignored. start is accepted only when the state is IDLE.
- A finish input already high when a wait state is entered, i.e. stale from the previous job: masked by the guard cycle.
- rst_n low mid-job: immediate return to IDLE and all outputs 0. Downstream units are reset by the same rst_n.
- Width rule: tiles is 16-bit with K≤65535. K=65535 gives 4096 tiles and must not overflow.

Optional Feature:
CTRL_TIMEOUT_EN
- Defined: a TO_W-bit counter clears on entry to each *_W state and increments every cycle spent there. At all-ones it sets err and forces FIN, so done rises with err=1.
- Undefined: the counter is not instantiated, and the wait states block indefinitely.

Decomposition:
- Shared package/define file: state one-hot encodings, TILE_K/TILE_LOG2 defaults, and the err cause codes if they are later exported.
- Natural sub-module: tpu_wait_done. It holds the guard cycle, the seen-latch and the optional timeout for one handshake. It is instantiated per wait state, or once and shared because the waits are mutually exclusive.

Test Plan:
- M=4,N=4,K=16, all finishes returned 3 cycles after each start → one reshape_start, one comp_start, one wb_start, tile_idx=0, done=1, err=0.
- K=40 → tiles=3. comp_start/wb_start each pulse 3 times with tile_idx 0,1,2. reshape_start pulses once.
- fm_finish returns 2 cycles after reshape_start and w_finish 9 cycles after → COMP is not entered before both. Verify again with the order swapped.
- K=0 → err=1, done=1, no downstream start pulse issued.
- Finish inputs held high from the previous job, then new start → guard cycle masks them; no early advance.
- rst_n asserted in COMP_W → all outputs 0 next cycle. With CTRL_TIMEOUT_EN and TO_W=6, comp_finish never returned → err=1 and done=1 after 63 wait cycles.

Source files
------------

// File: rtl/tpu_seq_ctrl_pkg.sv
// Shared definitions for the NaiveTPU matrix-path sequencer.
// Optional watchdog is enabled by defining CTRL_TIMEOUT_EN.
package tpu_seq_ctrl_pkg;

  localparam int TILE_K_DEF    = 16;
  localparam int TILE_LOG2_DEF = 4;
  localparam int TO_W_DEF      = 20;

  // One-hot sequencer states
  typedef enum logic [9:0] {
    S_IDLE   = 10'b00_0000_0001,
    S_LATCH  = 10'b00_0000_0010,
    S_RSH    = 10'b00_0000_0100,
    S_RSH_W  = 10'b00_0000_1000,
    S_COMP   = 10'b00_0001_0000,
    S_COMP_W = 10'b00_0010_0000,
    S_WB     = 10'b00_0100_0000,
    S_WB_W   = 10'b00_1000_0000,
    S_NEXT   = 10'b01_0000_0000,
    S_FIN    = 10'b10_0000_0000
  } state_e;

  // Error causes, reserved for a future status register
  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DIM     = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_cause_e;

  // Number of K-tiles; k is non-zero here, so k-1 cannot wrap and
  // K=65535 yields 4096 without overflowing 16 bits.
  function automatic logic [15:0] tile_count(input logic [15:0] k, input int log2);
    return ((k - 16'd1) >> log2) + 16'd1;
  endfunction

endpackage

// File: rtl/tpu_wait_done.sv
// Handshake waiter shared by all *_W states: guard cycle, per-input
// "seen" latches and (with CTRL_TIMEOUT_EN) a watchdog counter.
module tpu_wait_done #(
  parameter int TO_W = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arm,      // cycle before a wait state: reset tracking
  input  logic wait_en,  // currently in a wait state
  input  logic fin_a,
  input  logic fin_b,
  output logic ok,       // both finishes observed after the guard
  output logic timeout
);

  if (TO_W < 2) begin : g_bad_to
    $error("TO_W must be at least 2");
  end

  logic guard_q, guard_d;
  logic seen_a_q, seen_a_d;
  logic seen_b_q, seen_b_d;
  logic live;

  // Guard masks the first wait cycle, where a stale finish may still be high
  always_comb begin
    live     = wait_en & ~guard_q;
    guard_d  = arm ? 1'b1 : (wait_en ? 1'b0 : guard_q);
    seen_a_d = arm ? 1'b0 : (seen_a_q | (live & fin_a));
    seen_b_d = arm ? 1'b0 : (seen_b_q | (live & fin_b));
    ok       = live & (seen_a_q | fin_a) & (seen_b_q | fin_b);
  end

  // Guard and seen state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guard_q  <= 1'b0;
      seen_a_q <= 1'b0;
      seen_b_q <= 1'b0;
    end else begin
      guard_q  <= guard_d;
      seen_a_q <= seen_a_d;
      seen_b_q <= seen_b_d;
    end
  end

`ifdef CTRL_TIMEOUT_EN
  logic [TO_W-1:0] cnt_q, cnt_d;

  // Watchdog counts cycles spent in the current wait, saturating at all-ones
  always_comb begin
    cnt_d   = cnt_q;
    if (arm)
      cnt_d = '0;
    else if (wait_en && !(&cnt_q))
      cnt_d = cnt_q + TO_W'(1);
    timeout = wait_en & (&cnt_q);
  end

  // Watchdog register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/tpu_seq_ctrl.sv
// NaiveTPU matrix-path sequencer: latch dims, reshape once, then
// compute + writeback per K-tile, sticky done/err for the PS.
// Optional watchdog on every wait state: CTRL_TIMEOUT_EN.
module tpu_seq_ctrl
  import tpu_seq_ctrl_pkg::*;
#(
  parameter int TILE_K    = TILE_K_DEF,
  parameter int TILE_LOG2 = TILE_LOG2_DEF,
  parameter int TO_W      = TO_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] M,
  input  logic [15:0] N,
  input  logic [15:0] K,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] cfg_M,
  output logic [15:0] cfg_N,
  output logic [15:0] cfg_K,
  output logic        reshape_start,
  input  logic        fm_finish,
  input  logic        w_finish,
  output logic        comp_start,
  output logic [15:0] tile_idx,
  input  logic        comp_finish,
  output logic        wb_start,
  input  logic        wb_finish
);

  if (TILE_K != (1 << TILE_LOG2)) begin : g_bad_tile
    $error("TILE_K must equal 2**TILE_LOG2");
  end

  state_e      state_q, state_d;
  logic [15:0] cfg_m_q, cfg_m_d, cfg_n_q, cfg_n_d, cfg_k_q, cfg_k_d;
  logic [15:0] tiles_q, tiles_d, tile_idx_q, tile_idx_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        rsh_q, rsh_d, comp_q, comp_d, wb_q, wb_d;
  logic        arm, wait_en, fin_a, fin_b, wt_ok, wt_to;

  // Route the finish inputs of the active handshake to the shared waiter
  always_comb begin
    arm     = (state_q == S_RSH) || (state_q == S_COMP) || (state_q == S_WB);
    wait_en = (state_q == S_RSH_W) || (state_q == S_COMP_W) || (state_q == S_WB_W);
    fin_a   = 1'b0;
    fin_b   = 1'b0;
    case (state_q)
      S_RSH_W:  begin fin_a = fm_finish;   fin_b = w_finish;    end
      S_COMP_W: begin fin_a = comp_finish; fin_b = comp_finish; end
      S_WB_W:   begin fin_a = wb_finish;   fin_b = wb_finish;   end
      default:  ;
    endcase
  end

  tpu_wait_done #(.TO_W(TO_W)) u_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .arm     (arm),
    .wait_en (wait_en),
    .fin_a   (fin_a),
    .fin_b   (fin_b),
    .ok      (wt_ok),
    .timeout (wt_to)
  );

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    cfg_m_d    = cfg_m_q;
    cfg_n_d    = cfg_n_q;
    cfg_k_d    = cfg_k_q;
    tiles_d    = tiles_q;
    tile_idx_d = tile_idx_q;
    done_d     = done_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: if (start) begin
        cfg_m_d = M;
        cfg_n_d = N;
        cfg_k_d = K;
        done_d  = 1'b0;
        err_d   = 1'b0;
        state_d = S_LATCH;
      end
      S_LATCH: if (cfg_m_q == 16'd0 || cfg_n_q == 16'd0 || cfg_k_q == 16'd0) begin
        err_d   = 1'b1;
        state_d = S_FIN;
      end else begin
        tiles_d    = tile_count(cfg_k_q, TILE_LOG2);
        tile_idx_d = 16'd0;
        state_d    = S_RSH;
      end
      S_RSH:  state_d = S_RSH_W;
      S_COMP: state_d = S_COMP_W;
      S_WB:   state_d = S_WB_W;
      S_RSH_W, S_COMP_W, S_WB_W: begin
        if (wt_ok) begin
          state_d = (state_q == S_RSH_W)  ? S_COMP :
                    (state_q == S_COMP_W) ? S_WB   : S_NEXT;
        end else if (wt_to) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_NEXT: if (tile_idx_q == tiles_q - 16'd1) begin
        state_d = S_FIN;
      end else begin
        tile_idx_d = tile_idx_q + 16'd1;
        state_d    = S_COMP;
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Pulses coincide with their launch state; busy lags state by one edge
    busy_d = (state_q != S_IDLE) && (state_q != S_FIN);
    rsh_d  = (state_d == S_RSH);
    comp_d = (state_d == S_COMP);
    wb_d   = (state_d == S_WB);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cfg_m_q    <= '0;
      cfg_n_q    <= '0;
      cfg_k_q    <= '0;
      tiles_q    <= '0;
      tile_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rsh_q      <= 1'b0;
      comp_q     <= 1'b0;
      wb_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_m_q    <= cfg_m_d;
      cfg_n_q    <= cfg_n_d;
      cfg_k_q    <= cfg_k_d;
      tiles_q    <= tiles_d;
      tile_idx_q <= tile_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rsh_q      <= rsh_d;
      comp_q     <= comp_d;
      wb_q       <= wb_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign cfg_M         = cfg_m_q;
  assign cfg_N         = cfg_n_q;
  assign cfg_K         = cfg_k_q;
  assign reshape_start = rsh_q;
  assign comp_start    = comp_q;
  assign wb_start      = wb_q;
  assign tile_idx      = tile_idx_q;

endmodule
